ps2_keyboard: RTL and testbench

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_keyboard.sv | 138 +++++++++++++
 tb/tb_ps2_keyboard.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes the PS/2 bus, deframes 11-bit frames and
// folds E0/F0 prefixes into a single {ext, brk, code} key event.
module ps2_keyboard #(
   parameter int TIMEOUT_CYC = 100000,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [9:0] keydata,
   output logic       ready,
   output logic       perr
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // Odd parity over data byte plus parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
      return ^{b, p};
   endfunction

   logic [SYNC_STAGES-1:0] clk_sync_r;
   logic [SYNC_STAGES-1:0] data_sync_r;
   logic                   clk_prev_r;
   logic                   fall_s;
   logic                   sdata_s;

   state_t     state_r;
   logic [2:0] bitcnt_r;
   logic [7:0] shift_r;
   logic       par_r;
   logic [TW-1:0] tmo_r;
   logic       ext_pend_r;
   logic       brk_pend_r;

   // Synchronizers, idle-high after reset so no false edge appears.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync_r  <= {SYNC_STAGES{1'b1}};
         data_sync_r <= {SYNC_STAGES{1'b1}};
         clk_prev_r  <= 1'b1;
      end else begin
         clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
         data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
         clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
      end
   end

   assign fall_s  = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
   assign sdata_s = data_sync_r[SYNC_STAGES-1];

   // Frame receiver, timeout supervisor and key-event decoder.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         bitcnt_r   <= 3'd0;
         shift_r    <= 8'h00;
         par_r      <= 1'b0;
         tmo_r      <= '0;
         ext_pend_r <= 1'b0;
         brk_pend_r <= 1'b0;
         keydata    <= 10'h000;
         ready      <= 1'b0;
         perr       <= 1'b0;
      end else begin
         ready <= 1'b0;
         if (fall_s) begin
            // An edge always wins over a coincident timeout.
            tmo_r <= '0;
            case (state_r)
               IDLE: begin
                  if (!sdata_s) begin
                     state_r  <= DATA;
                     bitcnt_r <= 3'd0;
                  end else begin
                     state_r <= IDLE;
                  end
               end
               DATA: begin
                  shift_r  <= {sdata_s, shift_r[7:1]};
                  bitcnt_r <= bitcnt_r + 3'd1;
                  if (bitcnt_r == 3'd7) begin
                     state_r <= PARITY;
                  end else begin
                     state_r <= DATA;
                  end
               end
               PARITY: begin
                  par_r   <= sdata_s;
                  state_r <= STOP;
               end
               STOP: begin
                  state_r <= IDLE;
                  if (!sdata_s || !odd_parity_ok(shift_r, par_r)) begin
                     perr       <= 1'b1;
                     ext_pend_r <= 1'b0;
                     brk_pend_r <= 1'b0;
                  end else if (shift_r == 8'hE0) begin
                     ext_pend_r <= 1'b1;
                  end else if (shift_r == 8'hF0) begin
                     brk_pend_r <= 1'b1;
                  end else begin
                     keydata    <= {ext_pend_r, brk_pend_r, shift_r};
                     ready      <= 1'b1;
                     perr       <= 1'b0;
                     ext_pend_r <= 1'b0;
                     brk_pend_r <= 1'b0;
                  end
               end
               default: begin
                  state_r <= IDLE;
               end
            endcase
         end else if (state_r != IDLE) begin
            if (tmo_r < TMO_MAX) begin
               tmo_r <= tmo_r + TW'(1);
            end else begin
               state_r  <= IDLE;
               bitcnt_r <= 3'd0;
               tmo_r    <= '0;
               perr     <= 1'b1;
            end
         end else begin
            tmo_r <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed protocol cases plus random
// byte streams compared against a byte-level reference model.
module tb_ps2_keyboard;

   localparam int TIMEOUT_CYC = 100;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 8;

   logic       clk;
   logic       rst;
   logic       ps2_clk;
   logic       ps2_data;
   logic [9:0] keydata;
   logic       ready;
   logic       perr;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0;
   int ready_cnt = 0;
   int last_ready_cyc = 0;
   int stop_cyc = 0;

   logic [9:0] m_key;
   logic       m_perr;
   logic       m_ext;
   logic       m_brk;

   ps2_keyboard #(.TIMEOUT_CYC(TIMEOUT_CYC), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk),
      .rst(rst),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .keydata(keydata),
      .ready(ready),
      .perr(perr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ready) begin
         ready_cnt      <= ready_cnt + 1;
         last_ready_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sends the first n bits of an 11-bit frame (bit 0 = start).
   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = f[i];
         repeat (HALF) @(posedge clk);
         #1;
         ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         repeat (HALF) @(posedge clk);
         #1;
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip, input logic bad_stop);
      logic p;
      p = (~^b) ^ flip;
      return {~bad_stop, p, b, 1'b0};
   endfunction

   task automatic model_reset();
      m_key  = 10'h000;
      m_perr = 1'b0;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
   endtask

   task automatic do_frame(input logic [7:0] b, input logic flip, input logic bad_stop);
      int c0;
      int exp_ev;
      c0 = ready_cnt;
      exp_ev = 0;
      send_bits(mk_frame(b, flip, bad_stop), 11);
      repeat (2) @(posedge clk);
      #1;
      if (flip || bad_stop) begin
         m_perr = 1'b1;
         m_ext  = 1'b0;
         m_brk  = 1'b0;
      end else if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         m_key  = {m_ext, m_brk, b};
         m_perr = 1'b0;
         m_ext  = 1'b0;
         m_brk  = 1'b0;
         exp_ev = 1;
      end
      chk("ready_count", 32'(ready_cnt - c0), 32'(exp_ev));
      chk("keydata", 32'(keydata), 32'(m_key));
      chk("perr", 32'(perr), 32'(m_perr));
      if (exp_ev == 1) chk("latency", 32'(last_ready_cyc - stop_cyc), 32'(SYNC_STAGES + 1));
   endtask

   initial begin
      int c0;
      logic [7:0] b;
      int r;
      rst = 1'b1;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      model_reset();
      repeat (5) @(posedge clk);
      #1;
      chk("rst_keydata", 32'(keydata), 32'h000);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_perr", 32'(perr), 32'h0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      do_frame(8'h1D, 1'b0, 1'b0);
      do_frame(8'hF0, 1'b0, 1'b0);
      do_frame(8'h1D, 1'b0, 1'b0);
      do_frame(8'h1C, 1'b0, 1'b0);
      do_frame(8'hE0, 1'b0, 1'b0);
      do_frame(8'hF0, 1'b0, 1'b0);
      do_frame(8'h75, 1'b0, 1'b0);
      do_frame(8'h4D, 1'b0, 1'b0);
      do_frame(8'hF0, 1'b0, 1'b0);
      do_frame(8'hE0, 1'b0, 1'b0);
      do_frame(8'hE0, 1'b0, 1'b0);
      do_frame(8'h75, 1'b0, 1'b0);
      do_frame(8'h1C, 1'b0, 1'b0);
      do_frame(8'h1C, 1'b0, 1'b0);
      do_frame(8'h1B, 1'b1, 1'b0);
      do_frame(8'h1B, 1'b0, 1'b0);
      do_frame(8'hE0, 1'b0, 1'b0);
      do_frame(8'h2A, 1'b0, 1'b1);
      do_frame(8'h2A, 1'b0, 1'b0);

      // Partial frame then bus silence: timeout must abort it.
      c0 = ready_cnt;
      send_bits(mk_frame(8'h1D, 1'b0, 1'b0), 4);
      repeat (TIMEOUT_CYC - 20) @(posedge clk);
      #1;
      chk("tmo_early_perr", 32'(perr), 32'(m_perr));
      repeat (40) @(posedge clk);
      #1;
      m_perr = 1'b1;
      chk("tmo_perr", 32'(perr), 32'(m_perr));
      chk("tmo_ready", 32'(ready_cnt - c0), 32'h0);
      chk("tmo_keydata", 32'(keydata), 32'(m_key));
      do_frame(8'h1C, 1'b0, 1'b0);

      // Reset in the middle of a frame.
      c0 = ready_cnt;
      send_bits(mk_frame(8'h1D, 1'b0, 1'b0), 6);
      rst = 1'b1;
      ps2_clk = 1'b1;
      ps2_data = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("midrst_keydata", 32'(keydata), 32'h000);
      chk("midrst_perr", 32'(perr), 32'h0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      do_frame(8'h1C, 1'b0, 1'b0);
      chk("midrst_ready_total", 32'(ready_cnt - c0), 32'h1);

      for (int i = 0; i < 50; i++) begin
         r = int'($urandom_range(0, 9));
         if (r == 0) b = 8'hE0;
         else if (r == 1) b = 8'hF0;
         else b = 8'($urandom_range(0, 255));
         r = int'($urandom_range(0, 15));
         do_frame(b, r == 0, r == 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
